// File: rtl/region_blitter_pkg.sv
// Shared geometry defaults and colour-field helper for the blitter, game FSM and sprite drawers.
package region_blitter_pkg;

    localparam int DEF_SCR_W = 160;
    localparam int DEF_SCR_H = 120;
    localparam int XW        = $clog2(DEF_SCR_W);
    localparam int YW        = $clog2(DEF_SCR_H);
    localparam int AW        = $clog2(DEF_SCR_W * DEF_SCR_H);
    localparam int COL_W     = 9;

    // Words wider than 64 bits are not supported by this helper.
    function automatic logic [31:0] col_field(input logic [63:0] word, input int lsb, input int width);
        logic [63:0] mask;
        mask = (64'd1 << width) - 64'd1;
        return 32'((word >> lsb) & mask);
    endfunction

endpackage

// File: rtl/raster_scan.sv
// Loadable row-major scan counters over a rectangle; registers addr, clip and last for
// the pixel currently presented so the address is valid the cycle after load/step.
module raster_scan
    import region_blitter_pkg::DEF_SCR_W, region_blitter_pkg::DEF_SCR_H;
#(
    parameter int SCR_W = DEF_SCR_W,
    parameter int SCR_H = DEF_SCR_H,
    localparam int XW = $clog2(SCR_W),
    localparam int YW = $clog2(SCR_H),
    localparam int AW = $clog2(SCR_W * SCR_H)
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          load,
    input  logic          step,
    input  logic [XW-1:0] x0,
    input  logic [YW-1:0] y0,
    input  logic [XW:0]   w,
    input  logic [YW:0]   h,
    output logic [XW-1:0] px,
    output logic [YW-1:0] py,
    output logic [AW-1:0] addr,
    output logic          clip,
    output logic          last
);

    // Row base is kept wide enough for off-screen rows so it never wraps into the screen.
    localparam int RW = XW + YW + 2;
    localparam logic [XW:0] XLIM = (XW+1)'(SCR_W);
    localparam logic [YW:0] YLIM = (YW+1)'(SCR_H);

    logic [XW:0]   cx, x_org, x_end, nx, nx_end;
    logic [YW:0]   cy, y_end, ny, ny_end;
    logic [RW-1:0] row, nrow;
    logic [AW-1:0] nsum;
    logic          nclip;

    always_comb begin
        nx     = cx;
        ny     = cy;
        nrow   = row;
        nx_end = x_end;
        ny_end = y_end;
        if (load) begin
            nx     = {1'b0, x0};
            ny     = {1'b0, y0};
            nrow   = RW'(y0) * RW'(SCR_W);
            nx_end = {1'b0, x0} + w - 1'b1;
            ny_end = {1'b0, y0} + h - 1'b1;
        end else if (cx == x_end) begin
            nx   = x_org;
            ny   = cy + 1'b1;
            nrow = row + RW'(SCR_W);
        end else begin
            nx = cx + 1'b1;
        end
        nclip = (nx >= XLIM) || (ny >= YLIM);
        nsum  = AW'(nrow + RW'(nx));
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            cx    <= '0;
            cy    <= '0;
            row   <= '0;
            x_org <= '0;
            x_end <= '0;
            y_end <= '0;
            addr  <= '0;
            clip  <= 1'b0;
            last  <= 1'b0;
        end else if (load || step) begin
            cx    <= nx;
            cy    <= ny;
            row   <= nrow;
            x_end <= nx_end;
            y_end <= ny_end;
            if (load) x_org <= {1'b0, x0};
            addr  <= nclip ? '0 : nsum;
            clip  <= nclip;
            last  <= (nx == nx_end) && (ny == ny_end);
        end
    end

    assign px = cx[XW-1:0];
    assign py = cy[YW-1:0];

endmodule

// File: rtl/region_blitter.sv
// Copies a rectangle of a selected source image to the VGA adapter at one pixel per clock.
// Define REGION_BLITTER_COLOUR_KEY_EN to add key_colour transparency.
module region_blitter
    import region_blitter_pkg::DEF_SCR_W, region_blitter_pkg::DEF_SCR_H, region_blitter_pkg::col_field;
#(
    parameter int SCR_W   = DEF_SCR_W,
    parameter int SCR_H   = DEF_SCR_H,
    parameter int NUM_SRC = 4,
    parameter int WORD_W  = 32,
    parameter int COL_W   = 9,
    parameter int COL_LSB = 8,
    parameter int MEM_LAT = 1,
    localparam int XW = $clog2(SCR_W),
    localparam int YW = $clog2(SCR_H),
    localparam int AW = $clog2(SCR_W * SCR_H),
    localparam int SW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic                      start,
    input  logic [SW-1:0]             sel,
    input  logic [XW-1:0]             x0,
    input  logic [YW-1:0]             y0,
    input  logic [XW:0]               w,
    input  logic [YW:0]               h,
`ifdef REGION_BLITTER_COLOUR_KEY_EN
    input  logic [COL_W-1:0]          key_colour,
`endif
    input  logic [NUM_SRC*WORD_W-1:0] src_q,
    output logic [AW-1:0]             addr,
    output logic [XW-1:0]             ox,
    output logic [YW-1:0]             oy,
    output logic [COL_W-1:0]          colour,
    output logic                      plot,
    output logic                      busy,
    output logic                      done
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;
    localparam int CW = $clog2(MEM_LAT + 1) + 1;

    logic [1:0]    state;
    logic [SW-1:0] sel_r;
    logic [CW-1:0] dcnt;
    logic [XW-1:0] px;
    logic [YW-1:0] py;
    logic          clip, last, scan_load, scan_step, vld_in, key_hit;
    logic [63:0]   word;
    logic [COL_W-1:0] colour_c;

    logic [MEM_LAT-1:0]         vld_pipe;
    logic [MEM_LAT-1:0][XW-1:0] ox_pipe;
    logic [MEM_LAT-1:0][YW-1:0] oy_pipe;

    assign scan_load = (state == S_IDLE) && start;
    assign scan_step = (state == S_RUN) && !last;
    assign vld_in    = (state == S_RUN) && !clip;

    raster_scan #(.SCR_W(SCR_W), .SCR_H(SCR_H)) u_scan (
        .clk    (clk),
        .resetn (resetn),
        .load   (scan_load),
        .step   (scan_step),
        .x0     (x0),
        .y0     (y0),
        .w      (w),
        .h      (h),
        .px     (px),
        .py     (py),
        .addr   (addr),
        .clip   (clip),
        .last   (last)
    );

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= S_IDLE;
            sel_r <= '0;
            dcnt  <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (start) begin
                    sel_r <= sel;
                    busy  <= 1'b1;
                    if (w == '0 || h == '0) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                    end else begin
                        state <= S_RUN;
                    end
                end
                S_RUN: if (last) begin
                    state <= S_DRAIN;
                    dcnt  <= '0;
                end
                S_DRAIN: if (dcnt == CW'(MEM_LAT)) begin
                    state <= S_DONE;
                    done  <= 1'b1;
                end else begin
                    dcnt <= dcnt + 1'b1;
                end
                default: begin
                    state <= S_IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Out-of-range selects leave word at zero, so such pixels plot colour 0.
    always_comb begin
        word = '0;
        for (int i = 0; i < NUM_SRC; i++)
            if (sel_r == SW'(i)) word = 64'(src_q[i*WORD_W +: WORD_W]);
    end

    assign colour_c = COL_W'(col_field(word, COL_LSB, COL_W));

`ifdef REGION_BLITTER_COLOUR_KEY_EN
    assign key_hit = (colour_c == key_colour);
`else
    assign key_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!resetn) begin
            vld_pipe <= '0;
            ox_pipe  <= '0;
            oy_pipe  <= '0;
            plot     <= 1'b0;
            ox       <= '0;
            oy       <= '0;
            colour   <= '0;
        end else begin
            vld_pipe[0] <= vld_in;
            ox_pipe[0]  <= px;
            oy_pipe[0]  <= py;
            for (int i = 1; i < MEM_LAT; i++) begin
                vld_pipe[i] <= vld_pipe[i-1];
                ox_pipe[i]  <= ox_pipe[i-1];
                oy_pipe[i]  <= oy_pipe[i-1];
            end
            plot   <= vld_pipe[MEM_LAT-1] && !key_hit;
            ox     <= ox_pipe[MEM_LAT-1];
            oy     <= oy_pipe[MEM_LAT-1];
            colour <= colour_c;
        end
    end

endmodule
